// File: rtl/cr_queue_defs.sv
// rtl/cr_queue_defs.sv - shared defaults, entry layout and clog2 helper for CR flow queues
package cr_queue_defs;

    localparam int CR_SEQ_W_DEF   = 32;
    localparam int CR_TX_ID_W_DEF = 4;
    localparam int CR_DEPTH_DEF   = 16;

    // "No packet" marker is the all-ones sequence number.
    localparam logic [CR_SEQ_W_DEF-1:0] CR_SEQ_NONE_DEF = '1;

    // Queue entry layout at the default widths: sequence number in the MSBs, tx id in the LSBs.
    typedef struct packed {
        logic [CR_SEQ_W_DEF-1:0]   seq;
        logic [CR_TX_ID_W_DEF-1:0] tx_id;
    } cr_entry_t;

    // Smallest r with 2**r >= n; usable in parameter defaults.
    function automatic int cr_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cr_sat_counter.sv
// rtl/cr_sat_counter.sv - saturating up-counter with synchronous clear
module cr_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear takes priority.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/cr_pkt_queue_ctrl.sv
// rtl/cr_pkt_queue_ctrl.sv - per-flow in-flight packet queue with handshakes, flush and drop count
module cr_pkt_queue_ctrl
    import cr_queue_defs::*;
#(
    parameter int                SEQ_W      = CR_SEQ_W_DEF,
    parameter int                TX_ID_W    = CR_TX_ID_W_DEF,
    parameter int                DEPTH      = CR_DEPTH_DEF,
    parameter int                IND_W      = cr_clog2(DEPTH),
    parameter logic [SEQ_W-1:0]  SEQ_NONE   = {SEQ_W{1'b1}},
    parameter int                DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  enq_valid,
    input  logic [SEQ_W-1:0]      enq_seq,
    input  logic [TX_ID_W-1:0]    enq_tx_id,
    output logic                  enq_ready,
    output logic                  deq_valid,
    output logic [SEQ_W-1:0]      deq_seq,
    output logic [TX_ID_W-1:0]    deq_tx_id,
    input  logic                  deq_ready,
    output logic [IND_W:0]        size,
    output logic                  full,
    output logic                  empty,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int             ENTRY_W   = SEQ_W + TX_ID_W;
    localparam logic [IND_W:0] DEPTH_SZ  = (IND_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [IND_W-1:0]   head_q;
    logic [IND_W-1:0]   tail_q;
    logic [IND_W:0]     size_q;

    logic enq_req;
    logic enq_fire;
    logic deq_fire;
    logic drop;

    // Flags come only from the registered occupancy, so ready/valid never loop back through the handshake inputs.
    always_comb begin
        full      = (size_q == DEPTH_SZ);
        empty     = (size_q == '0);
        enq_ready = !full;
        deq_valid = !empty;
        size      = size_q;
        deq_seq   = mem[head_q][ENTRY_W-1 -: SEQ_W];
        deq_tx_id = mem[head_q][TX_ID_W-1:0];
    end

    // A SEQ_NONE enqueue is a legacy no-op; flush swallows any enqueue without counting it as a drop.
    always_comb begin
        enq_req  = enq_valid && (enq_seq != SEQ_NONE) && !flush && !rst;
        enq_fire = enq_req && !full;
        drop     = enq_req && full;
        deq_fire = deq_valid && deq_ready && !flush && !rst;
    end

    // Entry storage is written on accepted enqueues only and is never cleared.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[tail_q] <= {enq_seq, enq_tx_id};
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy is tracked separately to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q <= '0;
            tail_q <= '0;
            size_q <= '0;
        end else begin
            if (enq_fire) begin
                tail_q <= tail_q + IND_W'(1);
            end
            if (deq_fire) begin
                head_q <= head_q + IND_W'(1);
            end
            if (enq_fire && !deq_fire) begin
                size_q <= size_q + (IND_W + 1)'(1);
            end else if (deq_fire && !enq_fire) begin
                size_q <= size_q - (IND_W + 1)'(1);
            end
        end
    end

    cr_sat_counter #(
        .W (DROP_CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (drop),
        .count (drop_cnt)
    );

endmodule

// File: tb/tb_cr_pkt_queue_ctrl.sv
// tb/tb_cr_pkt_queue_ctrl.sv - self-checking bench for cr_pkt_queue_ctrl
module tb_cr_pkt_queue_ctrl;

    localparam int          SEQ_W   = 32;
    localparam int          TX_ID_W = 4;
    localparam int          DEPTH   = 4;
    localparam int          DROP_W  = 2;
    localparam int          DROP_MX = 3;
    localparam logic [31:0] NONE    = 32'hFFFF_FFFF;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic               enq_valid = 1'b0;
    logic [SEQ_W-1:0]   enq_seq = '0;
    logic [TX_ID_W-1:0] enq_tx_id = '0;
    logic               enq_ready;
    logic               deq_valid;
    logic [SEQ_W-1:0]   deq_seq;
    logic [TX_ID_W-1:0] deq_tx_id;
    logic               deq_ready = 1'b0;
    logic [2:0]         size;
    logic               full;
    logic               empty;
    logic [DROP_W-1:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cr_pkt_queue_ctrl #(
        .SEQ_W      (SEQ_W),
        .TX_ID_W    (TX_ID_W),
        .DEPTH      (DEPTH),
        .DROP_CNT_W (DROP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_seq   (enq_seq),
        .enq_tx_id (enq_tx_id),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_seq   (deq_seq),
        .deq_tx_id (deq_tx_id),
        .deq_ready (deq_ready),
        .size      (size),
        .full      (full),
        .empty     (empty),
        .drop_cnt  (drop_cnt)
    );

    typedef struct {
        logic        r;
        logic        f;
        logic        ev;
        logic [31:0] seq;
        logic [3:0]  tx;
        logic        dr;
        int          sz;
        int          dp;
        logic [31:0] dseq;
        logic [3:0]  dtx;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic [31:0] seq;
        logic [3:0]  tx;
    } ent_t;

    ent_t model_q[$];
    int   model_drop;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic f, input logic ev, input logic [31:0] s,
                       input logic [3:0] t, input logic dr, input int sz, input int dp,
                       input logic [31:0] ds, input logic [3:0] dt);
        vec_t v;
        v.r = r; v.f = f; v.ev = ev; v.seq = s; v.tx = t; v.dr = dr;
        v.sz = sz; v.dp = dp; v.dseq = ds; v.dtx = dt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic f, input logic ev, input logic [31:0] s,
                         input logic [3:0] t, input logic dr);
        rst = r; flush = f; enq_valid = ev; enq_seq = s; enq_tx_id = t; deq_ready = dr;
    endtask

    // Compare every observable output against an expected occupancy, drop count and head entry.
    task automatic check_state(input string tag, input int sz, input int dp,
                               input logic [31:0] ds, input logic [3:0] dt);
        chk({tag, "_size"},      64'(size),      64'(sz));
        chk({tag, "_drop"},      64'(drop_cnt),  64'(dp));
        chk({tag, "_full"},      64'(full),      64'(sz == DEPTH));
        chk({tag, "_empty"},     64'(empty),     64'(sz == 0));
        chk({tag, "_enq_ready"}, 64'(enq_ready), 64'(sz != DEPTH));
        chk({tag, "_deq_valid"}, 64'(deq_valid), 64'(sz != 0));
        if (sz != 0) begin
            chk({tag, "_deq_seq"},   64'(deq_seq),   64'(ds));
            chk({tag, "_deq_tx_id"}, 64'(deq_tx_id), 64'(dt));
        end
    endtask

    initial begin
        // r f ev seq tx dr | size drop head_seq head_tx
        add(1, 0, 0, 0,    0, 0,  0, 0, 0,  0);
        add(0, 0, 1, 10,   1, 0,  1, 0, 10, 1);
        add(0, 0, 1, 11,   2, 0,  2, 0, 10, 1);
        add(0, 0, 1, 12,   3, 0,  3, 0, 10, 1);
        add(0, 0, 1, 13,   4, 0,  4, 0, 10, 1);
        add(0, 0, 1, 14,   5, 0,  4, 1, 10, 1);
        add(0, 0, 0, 0,    0, 1,  3, 1, 11, 2);
        add(0, 0, 0, 0,    0, 1,  2, 1, 12, 3);
        add(0, 0, 1, 20,   6, 0,  3, 1, 12, 3);
        add(0, 0, 1, 21,   7, 0,  4, 1, 12, 3);
        add(0, 0, 0, 0,    0, 1,  3, 1, 13, 4);
        add(0, 0, 0, 0,    0, 1,  2, 1, 20, 6);
        add(0, 0, 0, 0,    0, 1,  1, 1, 21, 7);
        add(0, 0, 0, 0,    0, 1,  0, 1, 0,  0);
        add(0, 0, 1, 30,   1, 0,  1, 1, 30, 1);
        add(0, 0, 1, 31,   2, 0,  2, 1, 30, 1);
        add(0, 0, 1, 32,   3, 1,  2, 1, 31, 2);
        add(0, 0, 1, 33,   4, 0,  3, 1, 31, 2);
        add(0, 0, 1, 34,   5, 0,  4, 1, 31, 2);
        add(0, 0, 1, 35,   6, 1,  3, 2, 32, 3);
        add(0, 0, 0, 0,    0, 1,  2, 2, 33, 4);
        add(0, 0, 0, 0,    0, 1,  1, 2, 34, 5);
        add(0, 0, 1, NONE, 9, 0,  1, 2, 34, 5);
        add(0, 0, 1, 40,   1, 0,  2, 2, 34, 5);
        add(0, 0, 0, 0,    0, 1,  1, 2, 40, 1);
        add(0, 0, 1, 41,   2, 0,  2, 2, 40, 1);
        add(0, 0, 1, 42,   3, 0,  3, 2, 40, 1);
        add(0, 1, 1, 43,   4, 1,  0, 2, 0,  0);
        add(0, 0, 1, 5,    5, 0,  1, 2, 5,  5);
        add(1, 0, 0, 0,    0, 0,  0, 0, 0,  0);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 32'(60 + k), 4'(k), 0, k + 1, 0, 60, 0);
        for (int k = 0; k < 5; k++) add(0, 0, 1, 32'(70 + k), 4'(k), 0, 4, (k < 3) ? k + 1 : 3, 60, 0);
        add(0, 1, 0, 0,    0, 0,  0, 3, 0,  0);
        add(1, 1, 1, 80,   2, 0,  0, 0, 0,  0);
        add(0, 0, 1, 81,   1, 0,  1, 0, 81, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].f, vecs[i].ev, vecs[i].seq, vecs[i].tx, vecs[i].dr);
            @(posedge clk);
            #1;
            check_state($sformatf("v%0d", i), vecs[i].sz, vecs[i].dp, vecs[i].dseq, vecs[i].dtx);
        end

        // Randomized traffic against a queue-based reference model.
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        model_q.delete();
        model_drop = 0;
        for (int c = 0; c < 1500; c++) begin
            logic        r, f, ev, dr;
            logic [31:0] s;
            logic [3:0]  t;
            bit          is_full;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 39) == 0);
            ev = ($urandom_range(0, 99) < 60);
            dr = ($urandom_range(0, 99) < 45);
            s  = ($urandom_range(0, 7) == 0) ? NONE : 32'($urandom_range(0, 65535));
            t  = 4'($urandom);
            drive(r, f, ev, s, t, dr);
            #1;
            // Handshake flags must reflect only the current occupancy, not this cycle's requests.
            chk($sformatf("r%0d_pre_enq_ready", c), 64'(enq_ready), 64'(model_q.size() != DEPTH));
            chk($sformatf("r%0d_pre_deq_valid", c), 64'(deq_valid), 64'(model_q.size() != 0));
            is_full = (model_q.size() == DEPTH);
            if (r) begin
                model_q.delete();
                model_drop = 0;
            end else if (f) begin
                model_q.delete();
            end else begin
                if (ev && s != NONE && is_full && model_drop < DROP_MX) model_drop++;
                if (dr && model_q.size() > 0) void'(model_q.pop_front());
                if (ev && s != NONE && !is_full) begin
                    ent_t e;
                    e.seq = s;
                    e.tx  = t;
                    model_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
            if (model_q.size() > 0)
                check_state($sformatf("r%0d", c), model_q.size(), model_drop, model_q[0].seq, model_q[0].tx);
            else
                check_state($sformatf("r%0d", c), 0, model_drop, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
